lif_synapse_integrator: RTL

LIF_SYNAPSE_INTEGRATOR -- requirements
Module: lif_synapse_integrator

---
 rtl/snn_pkg.sv | 17 +
 rtl/lif_synapse_integrator_potential.sv | 26 ++
 rtl/lif_synapse_integrator.sv | 119 +++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared widths and FSM state encoding for the LIF synapse integrator.
package snn_pkg;
  localparam int N_SYN     = 16;
  localparam int W_WIDTH   = 4;
  localparam int V_WIDTH   = 10;
  localparam int ACC_WIDTH = 8;
  localparam int IDX_WIDTH = 4;
  localparam int REF_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    UPDATE,
    REFRACT
  } state_t;
endpackage

// File: rtl/lif_synapse_integrator_potential.sv
// Combinational membrane update: saturating add, floored leak, threshold compare.
module lif_potential_update
  import snn_pkg::*;
#(
  parameter int THRESHOLD = 64,
  parameter int LEAK      = 2
) (
  input  logic [V_WIDTH-1:0]   v_mem,
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [V_WIDTH-1:0]   v_next,
  output logic                 fire
);
  localparam logic [V_WIDTH-1:0] LEAK_V   = V_WIDTH'(LEAK);
  localparam logic [V_WIDTH-1:0] THRESH_V = V_WIDTH'(THRESHOLD);

  logic [V_WIDTH:0]   sum;
  logic [V_WIDTH-1:0] sat;

  always_comb begin
    sum = {1'b0, v_mem} + (V_WIDTH + 1)'(acc);
    // carry out means the sum passed the top of the potential range
    sat    = sum[V_WIDTH] ? '1 : sum[V_WIDTH-1:0];
    v_next = (sat >= LEAK_V) ? (sat - LEAK_V) : '0;
    fire   = (v_next >= THRESH_V);
  end
endmodule

// File: rtl/lif_synapse_integrator.sv
// Leaky integrate-and-fire neuron: scans 16 synapses per timestep, integrates
// weights of active inputs, applies leak/threshold and enforces refractory steps.
module lif_synapse_integrator
  import snn_pkg::*;
#(
  parameter int THRESHOLD     = 64,
  parameter int LEAK          = 2,
  parameter int REFRACT_STEPS = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 step_start,
  input  logic [N_SYN-1:0]     pre_spikes,
  output logic [IDX_WIDTH-1:0] weight_addr,
  output logic                 weight_rd,
  input  logic [W_WIDTH-1:0]   weight_data,
  output logic                 busy,
  output logic                 step_done,
  output logic                 post_spike,
  output logic [V_WIDTH-1:0]   v_mem,
  output logic                 refractory
);
  state_t               state, state_nx;
  logic [N_SYN-1:0]     spikes;
  logic [IDX_WIDTH-1:0] idx;
  logic [ACC_WIDTH-1:0] acc;
  logic                 rd_d;
  logic [REF_WIDTH-1:0] refr_cnt;
  logic [V_WIDTH-1:0]   v_next;
  logic                 fire;

  lif_potential_update #(
    .THRESHOLD (THRESHOLD),
    .LEAK      (LEAK)
  ) u_update (
    .v_mem  (v_mem),
    .acc    (acc),
    .v_next (v_next),
    .fire   (fire)
  );

  assign refractory = (refr_cnt != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      spikes   <= '0;
      idx      <= '0;
      acc      <= '0;
      rd_d     <= 1'b0;
      refr_cnt <= '0;
      v_mem    <= '0;
    end else begin
      state <= state_nx;
      // weight_data answers the read issued one cycle earlier
      rd_d  <= weight_rd;
      case (state)
        IDLE: begin
          if (step_start) begin
            spikes <= pre_spikes;
            acc    <= '0;
            idx    <= '0;
          end
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (rd_d) acc <= acc + ACC_WIDTH'(weight_data);
        end
        DRAIN: begin
          if (rd_d) acc <= acc + ACC_WIDTH'(weight_data);
        end
        UPDATE: begin
          if (fire) begin
            v_mem    <= '0;
            refr_cnt <= REF_WIDTH'(REFRACT_STEPS);
          end else begin
            v_mem <= v_next;
          end
        end
        REFRACT: refr_cnt <= refr_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    weight_addr = '0;
    weight_rd   = 1'b0;
    busy        = 1'b1;
    step_done   = 1'b0;
    post_spike  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (step_start) state_nx = (refr_cnt != '0) ? REFRACT : SCAN;
      end
      SCAN: begin
        weight_addr = idx;
        weight_rd   = spikes[idx];
        if (idx == IDX_WIDTH'(N_SYN - 1)) state_nx = DRAIN;
      end
      DRAIN: state_nx = UPDATE;
      UPDATE: begin
        step_done  = 1'b1;
        post_spike = fire;
        state_nx   = IDLE;
      end
      REFRACT: begin
        step_done = 1'b1;
        state_nx  = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end
endmodule
